// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, the receive side of uart_tx with the same bit
// timing (UBRR+1 clocks per bit). It produces a one-clock valid strobe per good
// byte and a one-clock ferr strobe when the stop bit is sampled low.
// Optional build macro UART_RX_MAJORITY_EN: each sample becomes the majority of
// three consecutive synchronised rx values, which rejects single-clock glitches.
module uart_rx #(
  parameter int CLK_HZ = 40000000,
  parameter int BAUD   = 921600,
  parameter int UBRR   = CLK_HZ / BAUD,
  parameter int HALF   = UBRR / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       valid,
  output logic       ferr,
  output logic       bsy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  localparam logic [14:0] UBRR_L = 15'(UBRR);
  localparam logic [14:0] HALF_L = 15'(HALF);

  state_t      state;
  logic        sync1;
  logic        rx_s;
  logic [14:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shreg;
  logic        sample;

  // Two-flop synchroniser bringing the asynchronous line into the clk domain.
  // NOTE: both flops reset to 1 (the idle level) so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  // History of the two previous rx_s values, used for the 2-of-3 vote.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= 2'b11;
    end else begin
      hist <= {hist[0], rx_s};
    end
  end

  assign sample = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign sample = rx_s;
`endif

  // Receive FSM: counter timing, start qualification, data shift and stop check.
  // NOTE: every state register uses non-blocking assignment so all updates see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      dout  <= '0;
      valid <= 1'b0;
      ferr  <= 1'b0;
      bsy   <= 1'b0;
    end else begin
      valid <= 1'b0;
      ferr  <= 1'b0;
      if (cnt != 15'd0) cnt <= cnt - 15'd1;

      case (state)
        IDLE: begin
          bsy <= 1'b0;
          if (!rx_s) begin
            cnt   <= HALF_L;
            bsy   <= 1'b1;
            state <= START;
          end
        end

        START: begin
          if (cnt == 15'd0) begin
            if (sample) begin
              // Line went back high before mid-start: treat as noise.
              bsy   <= 1'b0;
              state <= IDLE;
            end else begin
              cnt   <= UBRR_L;
              idx   <= '0;
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (cnt == 15'd0) begin
            shreg <= {sample, shreg[7:1]};
            cnt   <= UBRR_L;
            idx   <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end
        end

        STOP: begin
          if (cnt == 15'd0) begin
            if (sample) begin
              dout  <= shreg;
              valid <= 1'b1;
              bsy   <= 1'b0;
              state <= IDLE;
            end else begin
              ferr  <= 1'b1;
              state <= WAIT_HIGH;
            end
          end
        end

        WAIT_HIGH: begin
          // A low stop bit may be a break; wait for the line to recover.
          if (rx_s) begin
            bsy   <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          bsy   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
8N1 UART receiver. It is the receive counterpart of the project's uart_tx and uses identical bit timing (40 MHz clock, 921600 baud). It deserialises the host-to-FPGA serial line into bytes for the SPI-flash command parser. Each good byte produces a one-clock valid strobe. A bad stop bit produces a framing-error strobe.

Parameters:
- CLK_HZ, 40000000, input clock frequency in Hz.
- BAUD, 921600, line rate.
- UBRR, CLK_HZ/BAUD (=43), bit-period reload value. One bit = UBRR+1 = 44 clocks, same as the transmitter.
- HALF, UBRR/2 (=21), reload value used to reach mid-start-bit.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rx  in  1  serial input; idle high; asynchronous to clk.
- dout  out  8  last correctly received byte.
- valid  out  1  one-clock strobe: dout was updated this cycle.
- ferr  out  1  one-clock strobe: stop bit sampled low.
- bsy  out  1  high while a frame is being received.

Behaviour:
- Reset: dout=0x00, valid=0, ferr=0, bsy=0, state=IDLE, counter=0. Both synchroniser flops reset to 1.
- Input synchronisation: rx passes through 2 flops to give rx_s. All decisions use rx_s only.
- Counter: 15 bits. Decrements each clock while >0. A state acts on the cycle where counter==0, and that same edge reloads it.
- valid and ferr default to 0 every cycle; each is a single-cycle pulse.
- IDLE: bsy=0. If rx_s==0: counter<=HALF, bsy<=1, go START.
- START, at counter==0 (22 clocks after detect):
  - rx_s==1: false start. Go IDLE, bsy<=0, no strobe.
  - rx_s==0: counter<=UBRR, bit index<=0, go DATA.
- DATA, at counter==0:
  - Shift the sample in LSB-first: shreg <= {sample, shreg[7:1]}. counter<=UBRR, index+1.
  - After the 8th sample go STOP.
- STOP, at counter==0:
  - Sample==1: dout<=shreg, valid<=1, bsy<=0, go IDLE.
  - Sample==0: ferr<=1, dout unchanged, go WAIT_HIGH.
- WAIT_HIGH: stay while rx_s==0 (break or stuck-low line). When rx_s==1: bsy<=0, go IDLE. No new start is detected until the line has gone high.
- Timing, taking edge E as the one that moves IDLE to START:
  - Data bit k is sampled at E+22+44*(k+1).
  - The stop bit is sampled at E+418; valid or ferr is high in the following cycle.
  - A new start bit is accepted from the cycle after the return to IDLE. Back-to-back frames from uart_tx are therefore received with no loss.
- rx changes outside the sampling points are ignored.
- Reset asserted mid-frame: every output and state returns to its reset value immediately and the partial byte is discarded. After release, a line already low is treated as a new start.
- Per-bit tolerance is ±1/2 bit minus 2 clocks of synchroniser latency. The frame must stay within ±4% baud mismatch.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: keep a 3-entry history of rx_s. Each sampling point (start check, data bits, stop) uses the majority of rx_s at counter values 2, 1 and 0. A single-clock glitch at a sample point is rejected.
- Undefined: the sample is rx_s at counter==0 only, and the history logic is not built.

Test Plan:
- Send 0x55 at 44 clocks/bit, idle before and after -> exactly one valid pulse, dout=0x55, ferr never high, bsy high from E+1 through the valid cycle.
- Send 0xA3 then 0x0F back-to-back, driven by a uart_tx instance -> two valid pulses 440 clocks apart, dout=0xA3 then 0x0F.
- Send a frame of 0x3C with the stop bit driven low, hold rx low 200 clocks, release, then send 0x81 -> ferr pulses once with dout still at its previous value, bsy stays high until rx returns high, then valid with dout=0x81.
- Drive a 10-clock low glitch on an idle line -> no valid, no ferr, bsy returns to 0 after 23 clocks.
- Assert rst low for 3 clocks during bit 4 of 0xFF, release, idle, then send 0x12 -> no strobe for the aborted frame, all outputs 0 during reset, then valid with dout=0x12.
- Send 0x00 with a 1-clock high pulse on rx placed at the bit-3 sample point -> macro defined: dout=0x00; macro undefined: dout=0x08.
